// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the vector ALU issue controller: opcodes, function codes,
// latency classes and controller state encoding.
package alu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b101010;

    // R-type function codes understood by the vector ALU
    localparam logic [5:0] VAND   = 6'b000001;
    localparam logic [5:0] VOR    = 6'b000010;
    localparam logic [5:0] VXOR   = 6'b000011;
    localparam logic [5:0] VNOT   = 6'b000100;
    localparam logic [5:0] VMOV   = 6'b000101;
    localparam logic [5:0] VADD   = 6'b000110;
    localparam logic [5:0] VSUB   = 6'b000111;
    localparam logic [5:0] VMULEU = 6'b001000;
    localparam logic [5:0] VMULOU = 6'b001001;
    localparam logic [5:0] VSLL   = 6'b001010;
    localparam logic [5:0] VSRL   = 6'b001011;
    localparam logic [5:0] VSRA   = 6'b001100;
    localparam logic [5:0] VROT   = 6'b001101;
    localparam logic [5:0] VDIV   = 6'b001110;
    localparam logic [5:0] VMOD   = 6'b001111;
    localparam logic [5:0] VSQEU  = 6'b010000;
    localparam logic [5:0] VSQOU  = 6'b010001;
    localparam logic [5:0] VSQRT  = 6'b010010;

    localparam int LAT_W = 8;

    typedef enum logic [1:0] {
        CLS_SIMPLE,
        CLS_MUL,
        CLS_LONG,
        CLS_ILLEGAL
    } lat_class_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_e;

    // A latency below one cycle would underflow the countdown, so floor it at one.
    function automatic logic [LAT_W-1:0] lat_clamp(input int lat);
        return (lat < 1) ? LAT_W'(1) : LAT_W'(lat);
    endfunction

endpackage

// File: rtl/alu_lat_class.sv
// Combinational decoder from (op_code, r_ins) to latency class and cycle count.
// Kept standalone so hazard logic can share the same classification.
module alu_lat_class
    import alu_ctrl_pkg::*;
#(
    parameter int LAT_SIMPLE = 1,
    parameter int LAT_MUL    = 2,
    parameter int LAT_LONG   = 4
) (
    input  logic [5:0]       op_code_i,
    input  logic [5:0]       r_ins_i,
    output lat_class_e       cls_o,
    output logic [LAT_W-1:0] lat_o,
    output logic             illegal_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        if (op_code_i == OP_RTYPE) begin
            case (r_ins_i)
                VAND, VOR, VXOR, VNOT, VMOV, VADD, VSUB,
                VSLL, VSRL, VSRA, VROT:         cls_o = CLS_SIMPLE;
                VMULEU, VMULOU, VSQEU, VSQOU:   cls_o = CLS_MUL;
                VDIV, VMOD, VSQRT:              cls_o = CLS_LONG;
                default:                        cls_o = CLS_ILLEGAL;
            endcase
        end
    end

    // Illegal codes still occupy one slot so the consumer sees a flagged result.
    always_comb begin
        case (cls_o)
            CLS_MUL:  lat_o = lat_clamp(LAT_MUL);
            CLS_LONG: lat_o = lat_clamp(LAT_LONG);
            default:  lat_o = lat_clamp(LAT_SIMPLE);
        endcase
    end

    assign illegal_o = (cls_o == CLS_ILLEGAL);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the combinational vector ALU: holds operands stable,
// waits the class latency, then presents the captured result on a valid/ready port.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int LAT_SIMPLE = 1,
    parameter int LAT_MUL    = 2,
    parameter int LAT_LONG   = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_op_code,
    input  logic [5:0]  in_r_ins,
    input  logic [1:0]  in_ww,
    input  logic [63:0] in_ra_val,
    input  logic [63:0] in_rb_val,
    input  logic [4:0]  in_rd,

    output logic [63:0] alu_ra,
    output logic [63:0] alu_rb,
    output logic [5:0]  alu_op_code,
    output logic [5:0]  alu_r_ins,
    output logic [1:0]  alu_ww,
    input  logic [63:0] alu_out,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_illegal,
    output logic        busy
);

    state_e            state_q;
    logic [LAT_W-1:0]  cnt_q;
    logic [4:0]        rd_q;
    logic              illegal_q;

    logic [63:0]       alu_ra_q;
    logic [63:0]       alu_rb_q;
    logic [5:0]        alu_op_code_q;
    logic [5:0]        alu_r_ins_q;
    logic [1:0]        alu_ww_q;

    logic              out_valid_q;
    logic [63:0]       out_result_q;
    logic [4:0]        out_rd_q;
    logic              out_illegal_q;

    lat_class_e        dec_cls;
    logic [LAT_W-1:0]  dec_lat;
    logic              dec_illegal;
    logic              accept;

    alu_lat_class #(
        .LAT_SIMPLE (LAT_SIMPLE),
        .LAT_MUL    (LAT_MUL),
        .LAT_LONG   (LAT_LONG)
    ) u_lat_class (
        .op_code_i  (in_op_code),
        .r_ins_i    (in_r_ins),
        .cls_o      (dec_cls),
        .lat_o      (dec_lat),
        .illegal_o  (dec_illegal)
    );

    // Accepting in DONE while the result drains gives back-to-back issue.
    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rd_q          <= '0;
            illegal_q     <= 1'b0;
            alu_ra_q      <= '0;
            alu_rb_q      <= '0;
            alu_op_code_q <= '0;
            alu_r_ins_q   <= '0;
            alu_ww_q      <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_rd_q      <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                alu_ra_q      <= in_ra_val;
                alu_rb_q      <= in_rb_val;
                alu_op_code_q <= in_op_code;
                alu_r_ins_q   <= in_r_ins;
                alu_ww_q      <= in_ww;
                rd_q          <= in_rd;
                illegal_q     <= dec_illegal;
                cnt_q         <= dec_lat - LAT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - LAT_W'(1);
                    end else begin
                        out_result_q  <= illegal_q ? 64'd0 : alu_out;
                        out_rd_q      <= rd_q;
                        out_illegal_q <= illegal_q;
                        out_valid_q   <= 1'b1;
                        state_q       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_ra      = alu_ra_q;
    assign alu_rb      = alu_rb_q;
    assign alu_op_code = alu_op_code_q;
    assign alu_r_ins   = alu_r_ins_q;
    assign alu_ww      = alu_ww_q;

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_illegal_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural stand-in for the vector ALU.
module tb_alu_issue_ctrl;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op_code;
    logic [5:0]  in_r_ins;
    logic [1:0]  in_ww;
    logic [63:0] in_ra_val;
    logic [63:0] in_rb_val;
    logic [4:0]  in_rd;
    logic [63:0] alu_ra;
    logic [63:0] alu_rb;
    logic [5:0]  alu_op_code;
    logic [5:0]  alu_r_ins;
    logic [1:0]  alu_ww;
    logic [63:0] alu_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op_code  (in_op_code),
        .in_r_ins    (in_r_ins),
        .in_ww       (in_ww),
        .in_ra_val   (in_ra_val),
        .in_rb_val   (in_rb_val),
        .in_rd       (in_rd),
        .alu_ra      (alu_ra),
        .alu_rb      (alu_rb),
        .alu_op_code (alu_op_code),
        .alu_r_ins   (alu_r_ins),
        .alu_ww      (alu_ww),
        .alu_out     (alu_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    // Whole-word stand-in for the ALU; the small test values never cross lanes.
    always_comb begin
        case (alu_r_ins)
            VAND:           alu_out = alu_ra & alu_rb;
            VOR:            alu_out = alu_ra | alu_rb;
            VXOR:           alu_out = alu_ra ^ alu_rb;
            VADD:           alu_out = alu_ra + alu_rb;
            VSUB:           alu_out = alu_ra - alu_rb;
            VMULEU, VMULOU: alu_out = alu_ra * alu_rb;
            VSQEU, VSQOU:   alu_out = alu_ra * alu_ra;
            VDIV:           alu_out = (alu_rb != 0) ? alu_ra / alu_rb : 64'd0;
            VMOD:           alu_out = (alu_rb != 0) ? alu_ra % alu_rb : 64'd0;
            VSQRT:          alu_out = 64'd4;
            default:        alu_out = 64'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [5:0] op, input logic [5:0] rins, input logic [1:0] ww,
                        input logic [63:0] ra, input logic [63:0] rb, input logic [4:0] rd);
        in_op_code = op;
        in_r_ins   = rins;
        in_ww      = ww;
        in_ra_val  = ra;
        in_rb_val  = rb;
        in_rd      = rd;
        in_valid   = 1'b1;
        #1;
        chk("in_ready_at_issue", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called just after an accept edge; returns at the negedge where out_valid is seen.
    task automatic wait_valid(input string tag, input int exp_edges);
        int edges;
        edges = 0;
        @(negedge clk);
        while (!out_valid && edges < 20) begin
            chk("in_ready_low_exec", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
            edges++;
        end
        chk(tag, 64'(edges), 64'(exp_edges));
    endtask

    task automatic expect_out(input string tag, input logic [63:0] res, input logic [4:0] rd,
                              input logic ill);
        chk({tag, "_valid"},   {63'd0, out_valid}, 64'd1);
        chk({tag, "_result"},  out_result, res);
        chk({tag, "_rd"},      {59'd0, out_rd}, {59'd0, rd});
        chk({tag, "_illegal"}, {63'd0, out_illegal}, {63'd0, ill});
        $display("txn %s: rd=%0d result=%0h illegal=%0b", tag, out_rd, out_result, out_illegal);
    endtask

    typedef struct {
        logic [5:0]  rins;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [4:0]  rd;
        int          lat;
        logic [63:0] res;
    } vec_t;

    vec_t stream [5];
    bit   seen;

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_op_code = '0;
        in_r_ins   = '0;
        in_ww      = '0;
        in_ra_val  = '0;
        in_rb_val  = '0;
        in_rd      = '0;
        out_ready  = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy",      {63'd0, busy}, 64'd0);
        chk("rst_alu_ra",    alu_ra, 64'd0);
        chk("rst_result",    out_result, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: VAND 15 & 14
        send(OP_RTYPE, VAND, 2'b00, 64'd15, 64'd14, 5'd3);
        chk("t1_alu_ra", alu_ra, 64'd15);
        chk("t1_alu_rins", {58'd0, alu_r_ins}, {58'd0, VAND});
        wait_valid("t1_latency", 1);
        expect_out("t1", 64'd14, 5'd3, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t1_drain_valid", {63'd0, out_valid}, 64'd0);
        chk("t1_drain_busy",  {63'd0, busy}, 64'd0);
        out_ready = 1'b0;

        // 2: VMOD 102 % 10, 64-bit elements
        send(OP_RTYPE, VMOD, 2'b11, 64'd102, 64'd10, 5'd7);
        chk("t2_alu_ww", {62'd0, alu_ww}, 64'd3);
        wait_valid("t2_latency", 4);
        expect_out("t2", 64'd2, 5'd7, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // 3: VMULOU stalled by the consumer, then back-to-back VADD
        send(OP_RTYPE, VMULOU, 2'b10, 64'd20, 64'd20, 5'd9);
        wait_valid("t3_latency", 2);
        for (int i = 0; i < 3; i++) begin
            expect_out("t3_hold", 64'd400, 5'd9, 1'b0);
            chk("t3_hold_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(OP_RTYPE, VADD, 2'b00, 64'd5, 64'd10, 5'd11);
        chk("t3_b2b_alu_rb", alu_rb, 64'd10);
        out_ready = 1'b0;
        wait_valid("t3_b2b_latency", 1);
        expect_out("t3_add", 64'd15, 5'd11, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // 4: asynchronous reset in the middle of VSQRT
        send(OP_RTYPE, VSQRT, 2'b11, 64'd16, 64'd0, 5'd13);
        @(negedge clk);
        chk("t4_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("t4_rst_alu_ra",    alu_ra, 64'd0);
        chk("t4_rst_alu_op",    {58'd0, alu_op_code}, 64'd0);
        chk("t4_rst_alu_rins",  {58'd0, alu_r_ins}, 64'd0);
        chk("t4_rst_result",    out_result, 64'd0);
        chk("t4_rst_rd",        {59'd0, out_rd}, 64'd0);
        chk("t4_rst_in_ready",  {63'd0, in_ready}, 64'd1);
        chk("t4_rst_busy",      {63'd0, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("t4_no_valid_after_rst", {63'd0, seen}, 64'd0);
        send(OP_RTYPE, VXOR, 2'b00, 64'd15, 64'd14, 5'd2);
        wait_valid("t4_xor_latency", 1);
        expect_out("t4_xor", 64'd1, 5'd2, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // 5: illegal function code and illegal primary opcode
        send(OP_RTYPE, 6'b111111, 2'b00, 64'd15, 64'd14, 5'd4);
        wait_valid("t5a_latency", 1);
        expect_out("t5a", 64'd0, 5'd4, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        send(6'b000000, VAND, 2'b00, 64'd15, 64'd14, 5'd5);
        wait_valid("t5b_latency", 1);
        expect_out("t5b", 64'd0, 5'd5, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);

        // 6: streamed mix with the consumer always ready
        stream[0] = '{VADD,   64'd3,   64'd4, 5'd1, 1, 64'd7};
        stream[1] = '{VMULEU, 64'd6,   64'd7, 5'd2, 2, 64'd42};
        stream[2] = '{VDIV,   64'd100, 64'd7, 5'd3, 4, 64'd14};
        stream[3] = '{VSUB,   64'd50,  64'd9, 5'd4, 1, 64'd41};
        stream[4] = '{VSQEU,  64'd9,   64'd0, 5'd5, 2, 64'd81};
        for (int i = 0; i < 5; i++) begin
            send(OP_RTYPE, stream[i].rins, 2'b01, stream[i].ra, stream[i].rb, stream[i].rd);
            wait_valid("t6_latency", stream[i].lat);
            expect_out("t6", stream[i].res, stream[i].rd, 1'b0);
        end
        @(negedge clk);
        chk("t6_end_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_end_busy",  {63'd0, busy}, 64'd0);
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/sequencing controller in front of the combinational vector ALU (64-bit operands, 6-bit Op_code, 6-bit R_ins, 2-bit WW).
- Accepts one R-type instruction at a time over a valid/ready handshake and registers its operands so the ALU inputs stay stable.
- Holds the ALU for a latency that depends on the function class (simple, multiply/square, divide/mod/sqrt), then presents the captured result with its destination tag on an output valid/ready handshake.

Parameters:
- LAT_SIMPLE, 1, cycles for logic, add/sub, shift, rotate ops.
- LAT_MUL, 2, cycles for VMULEU, VMULOU, VSQEU, VSQOU.
- LAT_LONG, 4, cycles for VDIV, VMOD, VSQRT; all LAT_* must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  controller can accept.
- in_op_code  in  6  primary opcode.
- in_r_ins  in  6  R-type function code.
- in_ww  in  2  element width: 00=8, 01=16, 10=32, 11=64.
- in_ra_val  in  64  rA contents, bit 0 = MSB.
- in_rb_val  in  64  rB contents, bit 0 = MSB.
- in_rd  in  5  destination register tag.
- alu_ra, alu_rb  out  64  registered operands to the ALU.
- alu_op_code, alu_r_ins  out  6  registered codes to the ALU.
- alu_ww  out  2  registered width to the ALU.
- alu_out  in  64  ALU combinational result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  64  captured result.
- out_rd  out  5  destination tag of the result.
- out_illegal  out  1  result came from an undefined or unsupported code.
- busy  out  1  state != IDLE.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - EXEC: counter running, in_ready=0.
  - DONE: out_valid=1.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This gives back-to-back issue with no bubble.
- Accept on a rising edge with in_valid & in_ready:
  - Register op_code, r_ins, ww, ra, rb, rd onto the alu_* outputs and the internal rd register.
  - Load cnt = LAT(class) - 1.
  - Go to EXEC.
- Latency class applies only when op_code==101010:
  - 000001-000111 and 001010-001101: LAT_SIMPLE.
  - 001000, 001001, 010000, 010001: LAT_MUL.
  - 001110, 001111, 010010: LAT_LONG.
- Illegal instructions: any other r_ins, or op_code!=101010, uses LAT_SIMPLE and sets the illegal flag.
- EXEC:
  - While cnt!=0, decrement each cycle.
  - At the edge where cnt==0, capture out_result = illegal ? 0 : alu_out, plus out_rd and out_illegal, then go to DONE.
  - out_valid therefore rises exactly LAT edges after the accept edge.
- alu_* outputs are stable from the accept edge until the next accept. They are not cleared on return to IDLE.
- DONE:
  - out_result, out_rd and out_illegal are held while out_ready=0.
  - out_ready=1 with no new accept: go to IDLE.
  - out_ready=1 with a simultaneous accept: go straight to EXEC with the new operands.
- in_valid while busy (EXEC) is ignored; the upstream must hold the instruction.
- Reset, asserted at any time including mid-EXEC or in DONE:
  - State goes to IDLE and cnt to 0.
  - All alu_*, out_result, out_rd and out_illegal go to 0; out_valid=0.
  - The in-flight instruction is discarded.
  - in_ready reads 1 during and after reset.
- No arithmetic is done in this block; result width is 64 and WW is passed through unchanged.

Decomposition:
- Package alu_ctrl_pkg holds:
  - OP_RTYPE=6'b101010.
  - All R_ins localparams (VAND..VSQRT).
  - Latency-class enum {CLS_SIMPLE, CLS_MUL, CLS_LONG, CLS_ILLEGAL}.
  - State encoding {IDLE, EXEC, DONE}.
- One sub-module, alu_lat_class: purely combinational decoder from (op_code, r_ins) to class and latency value. It is reused by the hazard logic later.

Test Plan:
1. VAND: ra=15, rb=14, r_ins=000001, rd=3 -> out_valid 1 edge after accept, out_result=14, out_rd=3, out_illegal=0.
2. VMOD: ra=102, rb=10, WW=11, r_ins=001111 -> in_ready=0 for 4 cycles, out_valid after 4 edges, out_result=2.
3. VMULOU: ra=20, rb=20, WW=10 -> result 400 after 2 edges. Hold out_ready=0 for 3 cycles: result and rd stable, in_ready=0. Then out_ready=1 with VADD 5+10 offered that cycle -> accepted same edge, result 15 one edge later.
4. Reset asserted mid-EXEC of VSQRT -> out_valid never rises. All outputs 0 immediately (asynchronous). in_ready=1. The next VXOR of 15 and 14 returns 1.
5. op_code=101010 with r_ins=111111, and separately op_code=000000 -> out_valid after 1 edge, out_result=0, out_illegal=1.
6. Stream of 5 mixed ops with out_ready tied 1 -> each result in order, accept-to-valid spacing 1/2/4 per class, no dropped or duplicated results.
